// File: rtl/benes_cfg_if.sv
// benes_cfg_if: valid/ready stream carrying one switch-setting word per Benes stage.
// The cfg_par signal exists only when BENES_CFG_PARITY_EN is defined.
interface benes_cfg_if #(parameter int W = 8);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_data;
    logic         cfg_last;
`ifdef BENES_CFG_PARITY_EN
    logic         cfg_par;
    modport master(output cfg_valid, cfg_data, cfg_last, cfg_par, input cfg_ready);
    modport slave(input cfg_valid, cfg_data, cfg_last, cfg_par, output cfg_ready);
`else
    modport master(output cfg_valid, cfg_data, cfg_last, input cfg_ready);
    modport slave(input cfg_valid, cfg_data, cfg_last, output cfg_ready);
`endif
endinterface

// File: rtl/benes_cfg_ctrl.sv
// benes_cfg_ctrl: collects a 7-stage Benes route in shadow registers and commits it atomically.
// Define BENES_CFG_PARITY_EN to add an even-parity check on every accepted word.
module benes_cfg_ctrl #(
    parameter int N_STAGE      = 7,
    parameter int SW_PER_STAGE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    benes_cfg_if.slave              cfg,
    input  logic                    swap_hold,
    output logic [SW_PER_STAGE-1:0] stage_set [N_STAGE-1:0],
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_err
);
    localparam int IW = $clog2(N_STAGE);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGE - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    logic [1:0]              state;
    logic [IW-1:0]           idx;
    logic [SW_PER_STAGE-1:0] shadow [N_STAGE-1:0];
    logic                    acc;
    logic                    at_last;
    logic                    bad;

    assign cfg.cfg_ready = state != PEND;
    assign cfg_busy      = state != IDLE;
    assign acc           = cfg.cfg_valid && cfg.cfg_ready;
    assign at_last       = idx == LAST_IDX;
    // idx is 0 in IDLE, so the same last-flag rule covers the first word of a burst
`ifdef BENES_CFG_PARITY_EN
    assign bad = (cfg.cfg_last != at_last) || (^{cfg.cfg_data, cfg.cfg_par});
`else
    assign bad = cfg.cfg_last != at_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            for (int i = 0; i < N_STAGE; i++) begin
                shadow[i]    <= '0;
                stage_set[i] <= '0;
            end
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= acc && bad;
            if (acc && bad) begin
                state <= IDLE;
                idx   <= '0;
                for (int i = 0; i < N_STAGE; i++) shadow[i] <= '0;
            end else if (acc) begin
                shadow[idx] <= cfg.cfg_data;
                idx         <= at_last ? '0 : idx + 1'b1;
                state       <= at_last ? PEND : LOAD;
            end else if (state == PEND && !swap_hold) begin
                stage_set <= shadow;
                cfg_done  <= 1'b1;
                state     <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// tb_benes_cfg_ctrl: directed bursts; done/err pulses checked against a queue of expected events.
module tb_benes_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       swap_hold = 1'b0;
    logic [7:0] stage_set [6:0];
    logic       cfg_busy, cfg_done, cfg_err;
    logic [55:0] ss_flat;
    int vecs = 0;
    int fails = 0;
    int stall = 0;

    typedef struct packed {
        logic        is_done;
        logic [55:0] set;
    } ev_t;
    ev_t exp_q[$];

    benes_cfg_if #(.W(8)) ifc();

    benes_cfg_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg(ifc), .swap_hold(swap_hold),
        .stage_set(stage_set), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        ss_flat = '0;
        for (int i = 0; i < 7; i++) ss_flat[i*8 +: 8] = stage_set[i];
    end

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (cfg_done || cfg_err)) begin
            ev_t e;
            vecs++;
            if (cfg_done && cfg_err) begin
                fails++;
                $display("FAIL pulse_overlap: done=%b err=%b, expected never both", cfg_done, cfg_err);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: done=%b err=%b, expected no pulse", cfg_done, cfg_err);
            end else begin
                e = exp_q.pop_front();
                if (cfg_done !== e.is_done || ss_flat !== e.set) begin
                    fails++;
                    $display("FAIL pulse_event: done=%b set=%h, expected done=%b set=%h",
                             cfg_done, ss_flat, e.is_done, e.set);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l, input logic bp);
        int w = 0;
        ifc.cfg_valid = 1'b1;
        ifc.cfg_data  = d;
        ifc.cfg_last  = l;
`ifdef BENES_CFG_PARITY_EN
        ifc.cfg_par   = (^d) ^ bp;
`endif
        while (!ifc.cfg_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        stall = w;
        if (w == 50) begin
            vecs++;
            fails++;
            $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, expected 1", ifc.cfg_ready, w);
        end
        @(posedge clk);
        #1;
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic send_burst(input logic [55:0] b, input int n, input int last_at, input int bad_at);
        for (int k = 0; k < n; k++) send(b[k*8 +: 8], k == last_at, k == bad_at);
    endtask

    localparam logic [55:0] BURST_A = 56'h40_20_10_08_04_02_01;
    localparam logic [55:0] BURST_B = 56'hA5_5A_C3_3C_0F_F0_FF;
    localparam logic [55:0] BURST_C = 56'h11_22_33_44_55_66_77;
    localparam logic [55:0] BURST_D = 56'h99_88_77_66_55_44_33;
    localparam logic [55:0] BURST_P = 56'h81_42_24_03_18_99_E7;

    initial begin
        ifc.cfg_valid = 1'b0;
        ifc.cfg_data  = '0;
        ifc.cfg_last  = 1'b0;
`ifdef BENES_CFG_PARITY_EN
        ifc.cfg_par   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", 56'(ifc.cfg_ready), 56'd1);
        check("reset_busy", 56'(cfg_busy), 56'd0);
        check("reset_done", 56'(cfg_done), 56'd0);
        check("reset_err", 56'(cfg_err), 56'd0);
        check("reset_stage_set", ss_flat, 56'd0);

        exp_q.push_back('{1'b1, BURST_A});
        send_burst(BURST_A, 7, 6, -1);
        check("pend_ready", 56'(ifc.cfg_ready), 56'd0);
        check("pend_busy", 56'(cfg_busy), 56'd1);
        check("pend_stage_set_old", ss_flat, 56'd0);
        @(posedge clk);
        #1;
        check("commit_a_stage_set", ss_flat, BURST_A);
        check("commit_a_ready", 56'(ifc.cfg_ready), 56'd1);

        exp_q.push_back('{1'b1, BURST_B});
        swap_hold = 1'b1;
        send(BURST_B[7:0], 1'b0, 1'b0);
        check("restart_no_stall", 56'(stall), 56'd0);
        for (int k = 1; k < 7; k++) send(BURST_B[k*8 +: 8], k == 6, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("hold_ready", 56'(ifc.cfg_ready), 56'd0);
            check("hold_stage_set", ss_flat, BURST_A);
            @(posedge clk);
            #1;
        end
        swap_hold = 1'b0;
        @(posedge clk);
        #1;
        check("commit_b_stage_set", ss_flat, BURST_B);

        exp_q.push_back('{1'b0, BURST_B});
        send_burst(BURST_C, 3, 2, -1);
        check("early_last_busy", 56'(cfg_busy), 56'd0);
        check("early_last_retained", ss_flat, BURST_B);
        exp_q.push_back('{1'b1, BURST_C});
        send_burst(BURST_C, 7, 6, -1);
        @(posedge clk);
        #1;
        check("commit_c_stage_set", ss_flat, BURST_C);

        exp_q.push_back('{1'b0, BURST_C});
        send_burst(BURST_D, 7, -1, -1);
        check("missing_last_busy", 56'(cfg_busy), 56'd0);
        @(posedge clk);
        #1;
        check("missing_last_retained", ss_flat, BURST_C);

        send_burst(BURST_D, 3, -1, -1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_stage_set", ss_flat, 56'd0);
        check("midreset_busy", 56'(cfg_busy), 56'd0);
        check("midreset_ready", 56'(ifc.cfg_ready), 56'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef BENES_CFG_PARITY_EN
        exp_q.push_back('{1'b0, 56'd0});
        send_burst(BURST_P, 4, 6, 3);
        check("parity_err_busy", 56'(cfg_busy), 56'd0);
        exp_q.push_back('{1'b1, BURST_P});
        send_burst(BURST_P, 7, 6, -1);
        @(posedge clk);
        #1;
        check("parity_commit", ss_flat, BURST_P);
`else
        exp_q.push_back('{1'b1, BURST_P});
        send_burst(BURST_P, 7, 6, -1);
        @(posedge clk);
        #1;
        check("nopar_commit", ss_flat, BURST_P);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 56'(exp_q.size()), 56'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
